skid_pipe_reg: RTL and testbench

//  Parametrised pipeline stage register with valid/ready handshake and a two-entry skid buffer.

---
 rtl/skid_pipe_reg.sv | 139 +++++++++++++
 tb/tb_skid_pipe_reg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/skid_pipe_reg.sv
// -----------------------------------------------------------------------------
// skid_pipe_reg
//   Pipeline stage register with a valid/ready handshake and a two-entry skid
//   buffer. It sustains one transfer per cycle. in_ready is derived only from
//   registered state and the local stall/flush/reset controls, so there is no
//   combinational path from out_ready to in_ready. The stage also supports
//   stage-local flush and stall, and keeps a saturating count of cycles in
//   which a valid output was held without being transferred.
//
// Parameters
//   WIDTH     payload width in bits
//   CNT_W     width of the hold-cycle counter
//   RESET_VAL value loaded into both data entries on reset or flush
//
// Ports
//   clk        in   1      clock, all state updates on posedge
//   reset      in   1      asynchronous active-high reset of all state
//   flush      in   1      synchronous stage clear; overrides stall and handshakes
//   stall      in   1      synchronous hold; blocks both handshakes this cycle
//   in_valid   in   1      upstream payload valid
//   in_ready   out  1      stage can accept a payload this cycle
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      payload presented downstream
//   out_ready  in   1      downstream accepts the payload
//   out_data   out  WIDTH  payload to the next stage (main entry)
//   hold_cnt   out  CNT_W  saturating count of held-valid cycles
// -----------------------------------------------------------------------------
module skid_pipe_reg #(
  parameter int unsigned           WIDTH     = 64,
  parameter int unsigned           CNT_W     = 32,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic [CNT_W-1:0] hold_q,  hold_d;

  logic in_fire;
  logic out_fire;

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // While reset is held, the stage refuses input even though the state is EMPTY.
  assign in_ready  = (state_q != TWO) & ~stall & ~flush & ~reset;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign hold_cnt  = hold_q;

  assign in_fire  = in_valid & in_ready;
  // A downstream accept during a flush cycle does not count as a transfer.
  assign out_fire = out_valid & out_ready & ~stall & ~flush;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    hold_d  = hold_q;

    if (out_valid && !out_fire && !flush) begin
      hold_d = sat_inc(hold_q);
    end

    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            // main keeps its last value; out_valid=0 qualifies it.
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_skid_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_skid_pipe_reg
//   Directed testbench for skid_pipe_reg (WIDTH=16, CNT_W=4, RESET_VAL=16'hDEAD).
//   A vector table covers streaming, backpressure, stall and flush. Hand-written
//   sequences cover asynchronous reset mid-operation and counter saturation.
// -----------------------------------------------------------------------------
module tb_skid_pipe_reg;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;
  localparam logic [W-1:0] RV = 16'hDEAD;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          stall;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] hold_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  skid_pipe_reg #(
    .WIDTH    (W),
    .CNT_W    (CW),
    .RESET_VAL(RV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .stall    (stall),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         fl;
    logic         st;
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         ir;   // in_ready expected before the edge
    logic         ov;   // outputs expected after the edge
    logic [W-1:0] od;
    logic [CW-1:0] hc;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic fl, input logic st, input logic iv,
                              input logic [W-1:0] id, input logic ordy,
                              input logic ir, input logic ov,
                              input logic [W-1:0] od, input logic [CW-1:0] hc);
    vec_t v;
    v.fl = fl; v.st = st; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.hc = hc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven 1 time unit after a posedge. in_ready is checked before
  // the next edge, and the registered outputs are checked 1 unit after it.
  task automatic apply(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    flush = v.fl; stall = v.st; in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
    #1;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, v.ir});
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v.ov});
    chk({tag, ".out_data"},  {16'd0, out_data},  {16'd0, v.od});
    chk({tag, ".hold_cnt"},  {28'd0, hold_cnt},  {28'd0, v.hc});
  endtask

  task automatic idle_inputs();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
  endtask

  initial begin
    //              fl st iv id        ordy ir ov od        hc
    // Stream 1,2,3 with out_ready held high
    tbl[0]  = mk(0, 0, 1, 16'h0001, 1, 1, 1, 16'h0001, 0);
    tbl[1]  = mk(0, 0, 1, 16'h0002, 1, 1, 1, 16'h0002, 0);
    tbl[2]  = mk(0, 0, 1, 16'h0003, 1, 1, 1, 16'h0003, 0);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0003, 0);
    // Backpressure: A, B fill both entries, C waits upstream
    tbl[4]  = mk(0, 0, 1, 16'h00A1, 0, 1, 1, 16'h00A1, 0);
    tbl[5]  = mk(0, 0, 1, 16'h00B2, 0, 1, 1, 16'h00A1, 1);
    tbl[6]  = mk(0, 0, 1, 16'h00C3, 0, 0, 1, 16'h00A1, 2);
    tbl[7]  = mk(0, 0, 1, 16'h00C3, 1, 0, 1, 16'h00B2, 2);
    tbl[8]  = mk(0, 0, 1, 16'h00C3, 1, 1, 1, 16'h00C3, 2);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'h00C3, 2);
    // Stall for three cycles while holding two entries
    tbl[10] = mk(0, 0, 1, 16'h0011, 0, 1, 1, 16'h0011, 2);
    tbl[11] = mk(0, 0, 1, 16'h0022, 0, 1, 1, 16'h0011, 3);
    tbl[12] = mk(0, 1, 1, 16'h0033, 1, 0, 1, 16'h0011, 4);
    tbl[13] = mk(0, 1, 1, 16'h0033, 1, 0, 1, 16'h0011, 5);
    tbl[14] = mk(0, 1, 1, 16'h0033, 1, 0, 1, 16'h0011, 6);
    tbl[15] = mk(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0022, 6);
    tbl[16] = mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0022, 6);
    // Flush while holding two entries, with stall and handshakes active
    tbl[17] = mk(0, 0, 1, 16'h0044, 0, 1, 1, 16'h0044, 6);
    tbl[18] = mk(0, 0, 1, 16'h0055, 0, 1, 1, 16'h0044, 7);
    tbl[19] = mk(1, 1, 1, 16'h0066, 1, 0, 0, RV,       7);
    tbl[20] = mk(0, 0, 0, 16'h0000, 1, 1, 0, RV,       7);

    // Reset state
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_data",  {16'd0, out_data},  {16'd0, RV});
    chk("rst.hold_cnt",  {28'd0, hold_cnt},  32'd0);
    chk("rst.in_ready",  {31'd0, in_ready},  32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst.in_ready_after", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      apply(i, tbl[i]);
    end

    // Asynchronous reset in the middle of a cycle while holding one entry
    idle_inputs();
    in_valid = 1'b1; in_data = 16'h0077;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("arst.pre_out_valid", {31'd0, out_valid}, 32'd1);
    chk("arst.pre_out_data",  {16'd0, out_data},  32'h0077);
    chk("arst.pre_hold_cnt",  {28'd0, hold_cnt},  32'd8);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst.out_data",  {16'd0, out_data},  {16'd0, RV});
    chk("arst.hold_cnt",  {28'd0, hold_cnt},  32'd0);
    chk("arst.in_ready",  {31'd0, in_ready},  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("arst.in_ready_after", {31'd0, in_ready}, 32'd1);

    // Hold-count saturation: one entry held for 20 cycles
    in_valid = 1'b1; in_data = 16'h0099; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("sat.start", {28'd0, hold_cnt}, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat.cyc%0d", k), {28'd0, hold_cnt}, (k > 15) ? 32'd15 : k);
    end
    chk("sat.out_valid", {31'd0, out_valid}, 32'd1);
    chk("sat.out_data",  {16'd0, out_data},  32'h0099);

    // Flush clears the data but leaves the counter alone
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("satflush.out_valid", {31'd0, out_valid}, 32'd0);
    chk("satflush.hold_cnt",  {28'd0, hold_cnt},  32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
